// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-loader types: FSM states and byte geometry.
// Used by ccff_loader and ccff_shifter.
package fpga_cfg_pkg;

   localparam int BYTE_W = 8;
   localparam int IDX_W  = $clog2(BYTE_W);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHIFT,
      DONE
   } cfg_state_e;

endpackage

// File: rtl/ccff_shifter.sv
// Byte load/shift register feeding the chain head, LSB first.
// head is a flop output; it holds while en is low.
module ccff_shifter
   import fpga_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              en,
   input  logic [BYTE_W-1:0] data,
   output logic              head,
   output logic [IDX_W-1:0]  idx,
   output logic              last
);

   logic [BYTE_W-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         idx <= '0;
      end else if (load) begin
         sr  <= data;
         idx <= '0;
      end else if (en) begin
         sr  <= {1'b0, sr[BYTE_W-1:1]};
         idx <= idx + 1'b1;
      end
   end

   assign head = sr[0];
   assign last = (idx == IDX_W'(BYTE_W - 1));

endmodule

// File: rtl/ccff_loader.sv
// Streams a byte-wide bitstream serially into a fabric config chain.
// Define CCFF_READBACK_EN to add the tail_ones readback counter.
module ccff_loader
   import fpga_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 64
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic [BYTE_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              prog_clk_en,
   output logic              busy,
   output logic              done
`ifdef CCFF_READBACK_EN
   ,
   output logic [15:0]       tail_ones
`endif
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LEN  = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   cfg_state_e       state;
   cfg_state_e       next;
   logic [CW-1:0]    bit_cnt;
   logic [IDX_W-1:0] idx;
   logic             byte_last;
   logic             chain_last;
   logic             go;
   logic             accept;
   logic             stop;

   assign go         = (state == IDLE || state == DONE) && start;
   assign accept     = (state == FETCH) && cfg_valid;
   assign chain_last = (bit_cnt == LAST);
   assign stop       = (state == SHIFT) &&
                       (byte_last || chain_last);

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) state <= IDLE;
      else               state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:    if (start) next = FETCH;
         FETCH:   if (cfg_valid) next = SHIFT;
         SHIFT: begin
            if (chain_last)     next = DONE;
            else if (byte_last) next = FETCH;
         end
         DONE:    if (start) next = FETCH;
         default: next = IDLE;
      endcase
   end

   // Counts bits already shifted; a final partial byte stops at LAST.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n)
         bit_cnt <= '0;
      else if (go)
         bit_cnt <= '0;
      else if (state == SHIFT && bit_cnt != LEN)
         bit_cnt <= bit_cnt + 1'b1;
   end

   ccff_shifter u_shifter (
      .clk   (prog_clk),
      .rst_n (prog_reset_n),
      .load  (accept),
      .en    ((state == SHIFT) && !stop),
      .data  (cfg_data),
      .head  (ccff_head),
      .idx   (idx),
      .last  (byte_last)
   );

   assign cfg_ready   = (state == FETCH);
   assign prog_clk_en = (state == SHIFT);
   assign busy        = (state == FETCH) || (state == SHIFT);
   assign done        = (state == DONE);

`ifdef CCFF_READBACK_EN
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n)
         tail_ones <= '0;
      else if (go)
         tail_ones <= '0;
      else if (prog_clk_en && ccff_tail)
         tail_ones <= tail_ones + 16'd1;
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with chains of 10, 16 and 8 bits.
// Readback checks are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start;
   logic [2:0] valid;
   logic [2:0] tail;
   logic [7:0] data [3];
   wire  [2:0] ready;
   wire  [2:0] head;
   wire  [2:0] en;
   wire  [2:0] busy;
   wire  [2:0] done;
`ifdef CCFF_READBACK_EN
   wire  [15:0] ones0;
   wire  [15:0] ones1;
   wire  [15:0] ones2;
`endif

   int total = 0;
   int bad   = 0;

   bit         cap [3][0:1023];
   int         capn [3] = '{0, 0, 0};
   int         drise [3] = '{0, 0, 0};
   logic [2:0] done_q = '0;

   always #5 clk = ~clk;

   ccff_loader #(.CHAIN_LEN(10)) u0 (
      .prog_clk(clk), .prog_reset_n(rst_n),
      .start(start[0]), .cfg_data(data[0]),
      .cfg_valid(valid[0]), .cfg_ready(ready[0]),
      .ccff_head(head[0]), .ccff_tail(tail[0]),
      .prog_clk_en(en[0]), .busy(busy[0]),
      .done(done[0])
`ifdef CCFF_READBACK_EN
      , .tail_ones(ones0)
`endif
   );

   ccff_loader #(.CHAIN_LEN(16)) u1 (
      .prog_clk(clk), .prog_reset_n(rst_n),
      .start(start[1]), .cfg_data(data[1]),
      .cfg_valid(valid[1]), .cfg_ready(ready[1]),
      .ccff_head(head[1]), .ccff_tail(tail[1]),
      .prog_clk_en(en[1]), .busy(busy[1]),
      .done(done[1])
`ifdef CCFF_READBACK_EN
      , .tail_ones(ones1)
`endif
   );

   ccff_loader #(.CHAIN_LEN(8)) u2 (
      .prog_clk(clk), .prog_reset_n(rst_n),
      .start(start[2]), .cfg_data(data[2]),
      .cfg_valid(valid[2]), .cfg_ready(ready[2]),
      .ccff_head(head[2]), .ccff_tail(tail[2]),
      .prog_clk_en(en[2]), .busy(busy[2]),
      .done(done[2])
`ifdef CCFF_READBACK_EN
      , .tail_ones(ones2)
`endif
   );

   // Fabric model: each enabled cycle captures the head bit once.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (en[k] && capn[k] < 1024) begin
            cap[k][capn[k]] <= head[k];
            capn[k] <= capn[k] + 1;
         end
         if (done[k] && !done_q[k])
            drise[k] <= drise[k] + 1;
      end
      done_q <= done;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h",
                  name, act, exp);
      end
   endtask

   task automatic run_load(input int k,
                           input logic [7:0] b0,
                           input logic [7:0] b1,
                           input int nb,
                           input int gap);
      logic [7:0] bytes [2];
      int t;
      bytes[0] = b0;
      bytes[1] = b1;
      start[k] = 1'b1;
      @(posedge clk);
      #1 start[k] = 1'b0;
      @(negedge clk);
      check("busy_after_start", 32'(busy[k]), 32'd1);
      check("done_cleared", 32'(done[k]), 32'd0);
      for (int b = 0; b < nb; b++) begin
         t = 0;
         while (!ready[k] && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!ready[k]) check("ready_timeout", 32'd0, 32'd1);
         if (b > 0) begin
            for (int g = 0; g < gap; g++) begin
               check("gap_en_low", 32'(en[k]), 32'd0);
               check("gap_head_hold", 32'(head[k]),
                     32'(cap[k][capn[k] - 1]));
               @(negedge clk);
            end
         end
         data[k]  = bytes[b];
         valid[k] = 1'b1;
         @(posedge clk);
         #1 valid[k] = 1'b0;
         @(negedge clk);
      end
      t = 0;
      while (!done[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("done_set", 32'(done[k]), 32'd1);
      check("busy_clear", 32'(busy[k]), 32'd0);
      check("ready_low_done", 32'(ready[k]), 32'd0);
   endtask

   task automatic verify(input string name, input int k,
                         input int base, input int rb,
                         input int len,
                         input logic [15:0] exp);
      logic [15:0] got;
      repeat (3) @(negedge clk);
      got = '0;
      for (int i = 0; i < len; i++)
         got[i] = cap[k][base + i];
      check({name, "_bits"}, 32'(got), 32'(exp));
      check({name, "_en_cycles"}, 32'(capn[k] - base),
            32'(len));
      check({name, "_done_once"}, 32'(drise[k] - rb), 32'd1);
   endtask

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs [5];
   int   base;
   int   rb;
   int   n;

   initial begin
      vecs[0] = '{8'hA5, 8'h03, 10'h3A5};
      vecs[1] = '{8'hFF, 8'hFF, 10'h3FF};
      vecs[2] = '{8'h00, 8'hFC, 10'h000};
      vecs[3] = '{8'h5A, 8'h02, 10'h25A};
      vecs[4] = '{8'h81, 8'hFD, 10'h181};

      start   = '0;
      valid   = '0;
      tail    = 3'b111;
      data[0] = '0;
      data[1] = '0;
      data[2] = '0;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_head", 32'(head), 32'd0);
      check("rst_en", 32'(en), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: 10-bit chain, two bytes, upper 6 bits dropped.
      for (int v = 0; v < 5; v++) begin
         base = capn[0];
         rb   = drise[0];
         run_load(0, vecs[v].b0, vecs[v].b1, 2, 0);
         verify("len10", 0, base, rb, 10, 16'(vecs[v].exp));
      end

      // 16-bit chain with a 4-cycle valid gap between bytes.
      base = capn[1];
      rb   = drise[1];
      run_load(1, 8'h3C, 8'hE1, 2, 4);
      verify("gap16", 1, base, rb, 16, 16'hE13C);

      // start pulsed mid-load must be ignored.
      base = capn[0];
      rb   = drise[0];
      fork
         run_load(0, 8'hA5, 8'h03, 2, 0);
         begin
            repeat (4) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
         end
      join
      verify("midstart", 0, base, rb, 10, 16'h3A5);
      repeat (5) @(negedge clk);
      check("midstart_no_rerun", 32'(capn[0] - base), 32'd10);

      // Reset after five bits of 0xFF.
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      @(negedge clk);
      data[0]  = 8'hFF;
      valid[0] = 1'b1;
      @(posedge clk);
      #1 valid[0] = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         @(negedge clk);
         if (en[0]) n++;
      end
      check("rst_mid_bits_seen", 32'(n), 32'd5);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_head", 32'(head[0]), 32'd0);
      check("rstmid_en", 32'(en[0]), 32'd0);
      check("rstmid_busy", 32'(busy[0]), 32'd0);
      check("rstmid_ready", 32'(ready[0]), 32'd0);
`ifdef CCFF_READBACK_EN
      check("rstmid_ones", 32'(ones0), 32'd0);
`endif
      base = capn[0];
      repeat (3) @(negedge clk);
      check("rstmid_no_shift", 32'(capn[0] - base), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      base = capn[0];
      rb   = drise[0];
      run_load(0, 8'hA5, 8'h03, 2, 0);
      verify("reload", 0, base, rb, 10, 16'h3A5);

      // 8-bit chain, tail tied high; second load checks the clear.
      for (int r = 0; r < 2; r++) begin
         base = capn[2];
         rb   = drise[2];
         run_load(2, 8'hC3, 8'h00, 1, 0);
         verify("len8", 2, base, rb, 8, 16'h00C3);
`ifdef CCFF_READBACK_EN
         check("tail_ones", 32'(ones2), 32'd8);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, giving the total configuration-chain length in bits (legal range 1 to 65535).
REQ-002 SHALL have port prog_clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port prog_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-005 SHALL have port cfg_data, input, 8, a bitstream byte.
REQ-006 SHALL have port cfg_valid, input, 1, meaning cfg_data is valid.
REQ-007 SHALL have port cfg_ready, output, 1, meaning the loader accepts cfg_data this cycle.
REQ-008 SHALL have port ccff_head, output, 1, the serial configuration bit driven into the fabric chain head.
REQ-009 SHALL have port ccff_tail, input, 1, the serial bit returned from the fabric chain tail.
REQ-010 SHALL have port prog_clk_en, output, 1, the shift enable for the fabric prog_clk gate.
REQ-011 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-012 SHALL have port done, output, 1, sticky load-complete flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, FETCH, SHIFT and DONE.
REQ-014 IDLE/DONE: start=1 SHALL go to FETCH, clear done, zero bit_cnt and set busy the next cycle.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL assert cfg_ready only in FETCH; a byte is accepted on the cycle cfg_valid&cfg_ready, and the FSM then goes to SHIFT.
REQ-017 SHIFT: SHALL present one bit per cycle, LSB first, on registered ccff_head, with prog_clk_en=1 in the same cycle.
REQ-018 The fabric SHALL capture ccff_head on the next prog_clk edge after each cycle in which prog_clk_en=1, so each bit is shifted exactly once.
REQ-019 After 8 bits, or when bit_cnt reaches CHAIN_LEN, SHALL leave SHIFT: to FETCH if bits remain, otherwise to DONE.
REQ-020 Unused high bits of the final byte (8*ceil(CHAIN_LEN/8)-CHAIN_LEN bits) SHALL be discarded and never shifted.
REQ-021 In FETCH with cfg_valid=0, prog_clk_en SHALL be 0 and ccff_head SHALL hold its value; the stall is unbounded.
REQ-022 prog_clk_en SHALL be high for exactly CHAIN_LEN cycles per load.
REQ-023 Entering DONE SHALL set done=1 and busy=0; done SHALL stay set until the next accepted start.
REQ-024 bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and saturate at CHAIN_LEN; it never wraps.

Reset
REQ-025 prog_reset_n=0 SHALL force IDLE, ccff_head=0, prog_clk_en=0, cfg_ready=0, busy=0, done=0, bit_cnt=0 and tail_ones=0, asynchronously.
REQ-026 Reset mid-load SHALL abort the load with no further shifting; the fabric chain content is then undefined and needs a full reload.

Configuration
REQ-027 With CCFF_READBACK_EN defined, SHALL add output tail_ones[15:0], the count of cycles with prog_clk_en=1 and ccff_tail=1 during the current load; it is cleared on accepted start and held in DONE.
REQ-028 Without CCFF_READBACK_EN, tail_ones and its counter SHALL NOT exist, and ccff_tail SHALL be unused.

Structure
REQ-029 SHALL take the FSM state enum and the byte width constant (8) from shared package fpga_cfg_pkg.
REQ-030 SHALL contain one sub-module, ccff_shifter: an 8-bit load/shift register with bit index, enable and last-bit flag.

Verification
REQ-031 CHAIN_LEN=10, bytes 0xA5 then 0x03, valid held high -> ccff_head = 1,0,1,0,0,1,0,1,1,1; prog_clk_en high 10 cycles; done=1; the upper 6 bits of 0x03 are not shifted.
REQ-032 CHAIN_LEN=16, 4-cycle cfg_valid gap between bytes -> prog_clk_en=0 and ccff_head held during the gap; total enable cycles = 16.
REQ-033 start pulsed mid-load -> no restart, bit sequence unchanged, done asserts once.
REQ-034 prog_reset_n low after bit 5 of 0xFF -> all outputs zero immediately; a new start reloads from bit 0.
REQ-035 CCFF_READBACK_EN, CHAIN_LEN=8, ccff_tail tied 1 -> tail_ones=8 at done; rebuild without the macro -> port absent and the bench compiles with it disabled.
